// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM access arbiter.
package ram_arb_pkg;

  localparam int NUM_PROC = 4;
  localparam int MAX_HOLD_DEFAULT = 16;
  localparam logic [3:0] IDLE_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: finds the first set request at or above rr_ptr, wrapping 3->0.
module rr_priority_pick
  import ram_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest match to rr_ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = rr_ptr;
    cand  = rr_ptr;
    for (int k = NUM_PROC - 1; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter granting one of four processors access to RAM1/RAM2.
// Optional hold timeout compiled in with `define RAM_ARB_TIMEOUT_EN.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_PROC = 4,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] req_bank,
  output logic [3:0] Selector,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic       release_now;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_priority_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    release_now = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        sel_d   = IDLE_SEL;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        if (pick_found) begin
          state_d = HOLD;
          owner_d = pick_idx;
          sel_d   = {1'b0, req_bank[pick_idx], pick_idx};
          grant_d = 4'b0001 << pick_idx;
          busy_d  = 1'b1;
`ifdef RAM_ARB_TIMEOUT_EN
          hold_cnt_d = CNT_W'(1);
`endif
        end
      end

      HOLD: begin
        if (!req[owner_q]) begin
          release_now = 1'b1;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        // Owner still requesting after MAX_HOLD cycles: force it off.
        else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
          release_now = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
`endif
        if (release_now) begin
          state_d  = RELEASE;
          sel_d    = IDLE_SEL;
          grant_d  = 4'b0000;
          busy_d   = 1'b1;
          rr_ptr_d = 2'((int'(owner_q) + 1) % NUM_PROC);
        end
      end

      RELEASE: begin
        state_d = IDLE;
        sel_d   = IDLE_SEL;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
        hold_cnt_d = '0;
`endif
      end

      default: begin
        state_d = IDLE;
        sel_d   = IDLE_SEL;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
      sel_q    <= IDLE_SEL;
      grant_q  <= 4'b0000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
    end
  end

`ifdef RAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign Selector = sel_q;
  assign grant    = grant_q;
  assign busy     = busy_q;

endmodule
